// File: rtl/ej32_mem_arb.sv
// EJ32 shared-memory arbiter: instruction fetch (IF) versus load/store (LS).
// LS wins by default and may lock the port across multi-byte bursts. Reads
// return one cycle after their grant, tagged with the requesting source.
// Optional feature macro: EJ32_ARB_STARVE_EN adds a fetch starvation counter
// that promotes IF over LS after STARVE_MAX consecutive denied cycles.
module ej32_mem_arb #(
    parameter int ASZ        = 17,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [ASZ-1:0] if_addr,
    output logic           if_gnt,
    input  logic           ls_req,
    input  logic           ls_we,
    input  logic           ls_lock,
    input  logic [ASZ-1:0] ls_addr,
    input  logic [7:0]     ls_wdata,
    output logic           ls_gnt,
    output logic           mem_cs,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_addr,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata,
    output logic           rd_vld,
    output logic           rd_src,
    output logic [7:0]     rd_data
);

    logic lock_q, lock_d;
    logic rd_vld_q, rd_vld_d;
    logic rd_src_q, rd_src_d;
    logic if_gnt_s, ls_gnt_s;
    logic promote_s;

`ifdef EJ32_ARB_STARVE_EN
    localparam int            CW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    assign promote_s = (cnt_q == SMAX);

    // Starvation counter: count denied fetch cycles, saturate, clear on grant or no request.
    always_comb begin
        cnt_d = cnt_q;
        if (if_req && !if_gnt_s) begin
            if (cnt_q == SMAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic starve_unused_s;

    assign promote_s       = 1'b0;
    assign starve_unused_s = (STARVE_MAX != 0);
`endif

    // Grant selection: a held lock belongs to LS, then promotion, then LS, then IF.
    always_comb begin
        if_gnt_s = 1'b0;
        ls_gnt_s = 1'b0;
        if (lock_q) begin
            ls_gnt_s = ls_req;
        end else if (promote_s && if_req) begin
            if_gnt_s = 1'b1;
        end else if (ls_req) begin
            ls_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end
    end

    // Lock next state: follow ls_lock on an LS grant; a gap keeps the lock unless ls_lock drops.
    always_comb begin
        lock_d = lock_q;
        if (ls_gnt_s) begin
            lock_d = ls_lock;
        end else if (!ls_req && !ls_lock) begin
            lock_d = 1'b0;
        end else begin
            lock_d = lock_q;
        end
    end

    // Read return tracking: any granted read produces exactly one return next cycle.
    always_comb begin
        rd_vld_d = if_gnt_s || (ls_gnt_s && !ls_we);
        rd_src_d = ls_gnt_s;
    end

    // Lock and read-return registers; reset drops any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_src_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            rd_vld_q <= rd_vld_d;
            rd_src_q <= rd_src_d;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign ls_gnt    = ls_gnt_s;
    assign mem_cs    = if_gnt_s | ls_gnt_s;
    assign mem_we    = ls_gnt_s & ls_we;
    assign mem_addr  = ls_gnt_s ? ls_addr : (if_gnt_s ? if_addr : {ASZ{1'b0}});
    assign mem_wdata = ls_gnt_s ? ls_wdata : 8'h00;
    assign rd_vld    = rd_vld_q;
    assign rd_src    = rd_src_q;
    assign rd_data   = mem_rdata;

endmodule
